rr_arbiter_8ch: RTL and testbench
=================================

// Module: rr_arbiter_8ch
// PURPOSE
//  8-channel round-robin arbiter. Produces a registered 3-bit grant index
//  plus a valid flag. Sits directly upstream of the 3-to-8 decoder stage,
//  which turns grant_idx into one-hot channel enables gated by grant_valid.
//  A grant is held until the owner releases it or a hold timeout expires.
// PARAMETERS
//  NUM_CH    8   channel count; fixed at 8 (grant_idx is 3 bits)
//  IDX_W     3   grant index width, $clog2(NUM_CH)
//  MAX_HOLD  16  max cycles one grant may be held; 0 = timeout disabled
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      synchronous, active-high reset
//  req         in   8      per-channel request, level; held while wanting bus
//  done        in   1      release strobe from the current owner
//  grant_valid out  1      grant_idx is valid and owned
//  grant_idx   out  3      index of granted channel (decoder input)
//  timeout     out  1      1-cycle pulse: grant was revoked by hold timeout
// BEHAVIOUR
//  Clocking: one clock; reset is synchronous and active-high.
//  Reset values: state=IDLE, ptr=0, hold_cnt=0, grant_valid=0,
//  grant_idx=0, timeout=0. Reset mid-grant drops the grant on the next edge.
//  FSM states: IDLE, GRANT.
//  IDLE: if req!=0, pick the first set req bit searching ptr, ptr+1, .. mod 8.
//    Register it into grant_idx, set grant_valid=1, hold_cnt=0, go to GRANT.
//    Latency is 1 clock from req sample to grant_valid high. If req==0, stay.
//  GRANT: hold_cnt increments each cycle. Release conditions, by priority:
//    (a) done=1.
//    (b) req[grant_idx]=0.
//    (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1. Sets timeout=1 next cycle.
//  On release: next cycle grant_valid=0, state=IDLE,
//    ptr=grant_idx+1 with 7 wrapping to 0.
//  Bubble: at least one grant_valid=0 cycle between any two grants. This
//    keeps decoder enables break-before-make.
//  done while in IDLE is ignored. Simultaneous done and timeout counts as
//    done: no timeout pulse.
//  grant_idx holds its last value while grant_valid=0. timeout is high only
//    in the first IDLE cycle after a timeout release.
//  hold_cnt width is $clog2(MAX_HOLD)+1. It saturates and never wraps.
// STRUCTURE
//  Shared package arb_pkg:
//    - NUM_CH, IDX_W
//    - state typedef {IDLE, GRANT}
//    - function next_ptr(idx) = (idx+1)%NUM_CH
//  One sub-module, rr_pick8: purely combinational. Inputs req[7:0], ptr[2:0];
//    outputs found, idx[2:0]. Implemented as rotate, priority-encode,
//    un-rotate.
//  Top level holds the FSM, ptr, hold_cnt and output registers.
// TESTING
//  1. req=8'h00 for 10 cycles after reset -> grant_valid=0, grant_idx=0,
//     timeout=0 throughout.
//  2. Fairness: req=8'hFF constant, done pulsed 1 cycle after each grant
//     -> grant_idx sequence 0,1,...,7,0, with one bubble cycle between grants.
//  3. Wrap: ptr=6 (after owner 5 released), req=8'h03 -> grant_idx=0 then 1.
//     ch0 drops req -> ptr=1 next.
//  4. Timeout: MAX_HOLD=16, req=8'h10 held, no done -> grant_valid high for
//     exactly 16 cycles, then timeout=1 for 1 cycle. Regrant to ch4 follows
//     the bubble.
//  5. Simultaneous: done=1 in the same cycle as hold_cnt==15 -> release,
//     timeout stays 0.
//  6. Reset mid-grant: rst=1 during GRANT(idx=3) -> next edge grant_valid=0,
//     grant_idx=0, ptr=0. After rst drops with req=8'h88, grant_idx=3.

Source files
------------

// File: rtl/arb_pkg.sv
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared constants, state type and pointer helper for the
//                8-channel round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

    localparam int NUM_CH = 8;
    localparam int IDX_W  = $clog2(NUM_CH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        return IDX_W'((32'(idx) + 1) % NUM_CH);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick8.sv
// ============================================================================
//  Module      : rr_pick8
//  Description : Combinational round-robin picker: first set request found
//                searching from ptr upward, modulo the channel count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick8
    import arb_pkg::*;
(
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic              found_o,
    output logic [IDX_W-1:0]  idx_o
);

    logic [2*NUM_CH-1:0] w_dbl;
    logic [NUM_CH-1:0]   w_rot;
    logic [IDX_W-1:0]    w_off;

    // Doubling the vector turns the rotate into a plain part-select.
    assign w_dbl = {req_i, req_i};
    assign w_rot = w_dbl[ptr_i +: NUM_CH];

    always_comb begin
        w_off = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDX_W'(i);
            end
        end
    end

    assign found_o = |req_i;
    assign idx_o   = ptr_i + w_off;

endmodule

`default_nettype wire

// File: rtl/rr_arbiter_8ch.sv
// ============================================================================
//  Module      : rr_arbiter_8ch
//  Description : 8-channel round-robin arbiter with registered grant index,
//                owner release, hold timeout and a mandatory bubble cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_8ch
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req_i,
    input  logic              done_i,
    output logic              grant_valid_o,
    output logic [IDX_W-1:0]  grant_idx_o,
    output logic              timeout_o
);

    localparam int HC_W = $clog2(MAX_HOLD) + 1;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HC_W-1:0]   hold_q, hold_d;
    logic              valid_q, valid_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              to_q, to_d;

    logic              w_found;
    logic [IDX_W-1:0]  w_pick;
    logic              w_hit;
    logic              w_release;

    rr_pick8 u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .found_o (w_found),
        .idx_o   (w_pick)
    );

    assign w_hit     = (MAX_HOLD != 0) && (hold_q == HC_W'(MAX_HOLD - 1));
    assign w_release = done_i || !req_i[idx_q] || w_hit;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_found) begin
                    idx_d   = w_pick;
                    valid_d = 1'b1;
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (w_release) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    ptr_d   = next_ptr(idx_q);
                    // Owner release (done or dropped req) outranks the timeout.
                    to_d    = w_hit && !done_i && req_i[idx_q];
                end else if (hold_q != '1) begin
                    hold_d  = hold_q + HC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            to_q    <= to_d;
        end
    end

    assign grant_valid_o = valid_q;
    assign grant_idx_o   = idx_q;
    assign timeout_o     = to_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_8ch.sv
// ============================================================================
//  Module      : tb_rr_arbiter_8ch
//  Description : Self-checking bench for rr_arbiter_8ch: directed vector
//                table, hand sequences and randomized traffic vs. a model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arbiter_8ch;

    localparam int MAXH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic       timeout;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: who owns the bus, how long, where to search next.
    bit m_valid;
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_to;

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic       ev;
        logic [2:0] ei;
        logic       et;
    } vec_t;

    vec_t tbl[$];

    rr_arbiter_8ch #(.MAX_HOLD(MAXH)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req),
        .done_i        (done),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx),
        .timeout_o     (timeout)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        if (rst) begin
            m_valid = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_to = 0;
        end else if (!m_valid) begin
            m_to = 0;
            for (int k = 0; k < 8; k++) begin
                if (req[(m_ptr + k) % 8]) begin
                    m_owner = (m_ptr + k) % 8;
                    m_valid = 1;
                    m_held  = 0;
                    break;
                end
            end
        end else begin
            bit expired;
            m_to    = 0;
            m_held  = m_held + 1;
            expired = (MAXH != 0) && (m_held == MAXH);
            if (done || !req[m_owner] || expired) begin
                m_to    = expired && !done && req[m_owner];
                m_valid = 0;
                m_ptr   = (m_owner + 1) % 8;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(input string nm, input bit ev, input int ei, input bit et);
        vectors++;
        if (grant_valid !== ev || grant_idx !== 3'(ei) || timeout !== et) begin
            miscompares++;
            $display("FAIL %s: got valid=%0b idx=%0d timeout=%0b, want valid=%0b idx=%0d timeout=%0b",
                     nm, grant_valid, grant_idx, timeout, ev, ei, et);
        end
    endtask

    task automatic check_model(input string nm);
        check(nm, m_valid, m_owner, m_to);
    endtask

    initial begin
        // Fairness: each grant released by done one cycle later, then a bubble.
        for (int k = 0; k <= 8; k++) begin
            tbl.push_back('{8'hFF, 1'b0, 1'b1, 3'(k % 8), 1'b0});
            tbl.push_back('{8'hFF, 1'b1, 1'b0, 3'(k % 8), 1'b0});
        end
        // Wrap: owner 5 released -> ptr 6, then req 03 grants 0, then 1.
        tbl.push_back('{8'h20, 1'b0, 1'b1, 3'd5, 1'b0});
        tbl.push_back('{8'h20, 1'b1, 1'b0, 3'd5, 1'b0});
        tbl.push_back('{8'h03, 1'b0, 1'b1, 3'd0, 1'b0});
        tbl.push_back('{8'h02, 1'b0, 1'b0, 3'd0, 1'b0});
        tbl.push_back('{8'h03, 1'b0, 1'b1, 3'd1, 1'b0});
        tbl.push_back('{8'h03, 1'b1, 1'b0, 3'd1, 1'b0});

        rst = 1'b1;
        cyc();
        check("reset", 1'b0, 0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("idle_noreq", 1'b0, 0, 1'b0);
        end

        foreach (tbl[i]) begin
            req  = tbl[i].req;
            done = tbl[i].done;
            cyc();
            check($sformatf("tbl[%0d]", i), tbl[i].ev, int'(tbl[i].ei), tbl[i].et);
        end
        done = 1'b0;
        req  = 8'h00;
        cyc();
        check("tbl_idle", 1'b0, 1, 1'b0);

        // Timeout: ch4 holds with no done for exactly MAXH cycles.
        req = 8'h10;
        for (int i = 0; i < MAXH; i++) begin
            cyc();
            check("to_hold", 1'b1, 4, 1'b0);
        end
        cyc();
        check("to_pulse", 1'b0, 4, 1'b1);
        cyc();
        check("to_regrant", 1'b1, 4, 1'b0);

        // done lands in the same cycle the hold counter reaches its limit.
        for (int i = 0; i < MAXH - 1; i++) begin
            cyc();
            check("sim_hold", 1'b1, 4, 1'b0);
        end
        done = 1'b1;
        cyc();
        check("sim_release", 1'b0, 4, 1'b0);
        done = 1'b0;
        req  = 8'h00;
        cyc();
        check("sim_idle", 1'b0, 4, 1'b0);

        // Reset mid-grant clears ptr, so req 88 restarts the search from 0.
        req = 8'h08;
        cyc();
        check("rst_grant", 1'b1, 3, 1'b0);
        rst = 1'b1;
        cyc();
        check("rst_drop", 1'b0, 0, 1'b0);
        rst = 1'b0;
        req = 8'h88;
        cyc();
        check("rst_regrant", 1'b1, 3, 1'b0);
        done = 1'b1;
        cyc();
        check("rst_release", 1'b0, 3, 1'b0);
        done = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 2) == 0) begin
                req = req ^ 8'(1 << $urandom_range(0, 7));
            end
            done = ($urandom_range(0, 19) == 0);
            cyc();
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
